imem_loader: RTL and testbench

- Program-load writer for the instruction memory: receives a little-endian byte stream, assembles 32-bit words and drives the memory write port sequentially from byte address 0.
- Sits between a byte source (UART receiver / test harness) and the instruction memory write port.
- Holds the CPU in reset while a load is in progress and releases it on completion.

---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_SIZE = 256,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_rst_n
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_FIN  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM = 3'd3;
`endif

  localparam logic [CNT_W:0] MEM_WORDS = (CNT_W+1)'(MEM_SIZE);

  logic [2:0]       state;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] len;
  logic [23:0]      word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic             xfer;
  logic [31:0]      word;
  logic [CNT_W-1:0] hdr_len;
  logic             last_byte;
  logic             last_word;
  logic             in_range;

  // Byte handshake and the word being completed by the current byte (header or data).
  always_comb begin
    xfer      = rx_valid && rx_ready;
    word      = {rx_data, word_buf};
    hdr_len   = word[CNT_W-1:0];
    last_byte = (byte_idx == 2'd3);
    last_word = (word_idx == (len - {{(CNT_W-1){1'b0}}, 1'b1}));
    in_range  = ({1'b0, word_idx} < MEM_WORDS);
  end

  // Load sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_idx  <= 2'd0;
      word_idx  <= '0;
      len       <= '0;
      word_buf  <= 24'd0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            cpu_rst_n <= 1'b0;
            rx_ready  <= 1'b1;
            byte_idx  <= 2'd0;
            word_idx  <= '0;
            len       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              len <= hdr_len;
              if ({1'b0, hdr_len} > MEM_WORDS) begin
                err <= 1'b1;
              end
              if (hdr_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= ST_CSUM;
`else
                rx_ready <= 1'b0;
                state    <= ST_FIN;
`endif
              end else begin
                state <= ST_DATA;
              end
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (last_byte) begin
              // Words past the end of memory are swallowed; address/data keep their last written values.
              if (in_range) begin
                mem_we    <= 1'b1;
                mem_wdata <= word;
                mem_addr  <= 32'({word_idx, 2'b00});
              end
              word_idx <= word_idx + {{(CNT_W-1){1'b0}}, 1'b1};
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= ST_CSUM;
`else
                rx_ready <= 1'b0;
                state    <= ST_FIN;
`endif
              end
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer) begin
            if (rx_data != csum) begin
              err <= 1'b1;
            end
            rx_ready <= 1'b0;
            state    <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
          rx_ready  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          cpu_rst_n <= 1'b1;
          rx_ready  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (MEM_SIZE=4): table-driven loads with a write scoreboard,
// plus hand sequences for mid-load reset. Follows IMEM_LOADER_CHECKSUM_EN if defined.
module tb_imem_loader;

  localparam int MEM   = 4;
  localparam int CNT_W = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  imem_loader #(.MEM_SIZE(MEM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    int          gap;
    logic [7:0]  corrupt;
    bit          poke;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          errors;
  int          checks;
  int          n_writes;
  wr_t         exp_q[$];
  vec_t        vecs[8];
  logic [31:0] wlist[8];
  logic [7:0]  csum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and score any write pulse visible after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit last);
    bit acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = rx_ready;
      tick();
    end
    rx_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    for (int g = 0; g < gap; g++) begin
      tick();
      if (!last) chk("rdy_in_gap", {31'd0, rx_ready}, 32'd1);
    end
  endtask

  task automatic run_load(input vec_t v);
    int          nw;
    int          total;
    int          k;
    bit          exp_err;
    logic [31:0] w;
    nw       = int'(v.hdr[CNT_W-1:0]);
    total    = 4 + 4 * nw + (CS_EN ? 1 : 0);
    k        = 0;
    csum     = 8'd0;
    n_writes = 0;
    exp_err  = v.exp_err || (CS_EN && (v.corrupt != 8'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("cpu_rst_during_load", {31'd0, cpu_rst_n}, 32'd0);
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("rdy_in_hdr", {31'd0, rx_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      w = v.hdr;
      send_byte(w[8*i +: 8], v.gap, k == total - 1);
      k++;
    end
    chk("err_after_hdr", {31'd0, err}, {31'd0, v.exp_err});
    for (int j = 0; j < nw; j++) begin
      if (v.poke && j == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_busy", {31'd0, busy}, 32'd1);
      end
      w = wlist[j % 8];
      if (j < MEM) exp_q.push_back('{addr: 32'(j * 4), data: w});
      for (int b = 0; b < 4; b++) begin
        csum = csum ^ w[8*b +: 8];
        send_byte(w[8*b +: 8], v.gap, k == total - 1);
        k++;
      end
    end
    if (CS_EN) begin
      send_byte(csum ^ v.corrupt, v.gap, 1'b1);
    end
    for (int t = 0; t < 10 && busy; t++) tick();
    chk("busy_cleared", {31'd0, busy}, 32'd0);
    chk("done_set", {31'd0, done}, 32'd1);
    chk("err_final", {31'd0, err}, {31'd0, exp_err});
    chk("cpu_released", {31'd0, cpu_rst_n}, 32'd1);
    chk("rdy_idle", {31'd0, rx_ready}, 32'd0);
    chk("write_count", 32'(n_writes), 32'(v.exp_writes));
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    n_writes = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;

    wlist[0] = 32'h0050_0093;
    wlist[1] = 32'h00A0_0113;
    wlist[2] = 32'hDEAD_BEEF;
    wlist[3] = 32'h1234_5678;
    wlist[4] = 32'hA5A5_5A5A;
    wlist[5] = 32'h0F0F_00FF;
    wlist[6] = 32'h8000_0001;
    wlist[7] = 32'h7FFF_FFFE;

    //              hdr           gap corrupt poke exp_err writes
    vecs[0] = '{32'h0000_0002, 0, 8'h00, 1'b0, 1'b0, 2};
    vecs[1] = '{32'h0000_0002, 3, 8'h00, 1'b0, 1'b0, 2};
    vecs[2] = '{32'h0000_0000, 0, 8'h00, 1'b0, 1'b0, 0};
    vecs[3] = '{32'h0000_0006, 0, 8'h00, 1'b0, 1'b1, 4};
    vecs[4] = '{32'h0000_0004, 1, 8'h00, 1'b0, 1'b0, 4};
    vecs[5] = '{32'h0001_0003, 0, 8'h00, 1'b0, 1'b0, 3};
    vecs[6] = '{32'h0000_0003, 0, 8'h00, 1'b1, 1'b0, 3};
    vecs[7] = '{32'h0000_0002, 0, 8'h01, 1'b0, 1'b0, 2};

    tick();
    tick();
    chk_reset_outputs();
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_load(vecs[i]);
      tick();
    end

    // Mid-load reset after the 5th data byte, then a normal load must still work.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    exp_q.push_back('{addr: 32'h0, data: wlist[0]});
    for (int b = 0; b < 5; b++) begin
      logic [63:0] pair;
      pair = {wlist[1], wlist[0]};
      send_byte(pair[8*b +: 8], 0, 1'b0);
    end
    chk("mid_first_write", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_load(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
